// File: rtl/fanin_pkg.sv
// Shared types and helpers for the fan-in merge block: default sizing,
// the buffered entry layout and the round-robin index wrap.
package fanin_pkg;

  localparam int NUM_IN_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 17;
  localparam int SRC_W_DEFAULT  = $clog2(NUM_IN_DEFAULT);

  // Buffered word tagged with the port that supplied it (default sizing).
  typedef struct packed {
    logic [SRC_W_DEFAULT-1:0]  src;
    logic [DATA_W_DEFAULT-1:0] data;
  } entry_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo NUM_IN. Grant is one-hot, or zero when disabled or nothing requests.
module rr_arbiter
  import fanin_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] grant,
  output logic [SRC_W-1:0]  idx
);

  logic found;
  int   cur;

  // NOTE: every output and scratch variable gets a default before the scan so
  // no path through the loop leaves a value unassigned (no inferred latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cur   = int'(ptr);
    for (int k = 0; k < NUM_IN; k++) begin
      if (en && !found && req[SRC_W'(cur)]) begin
        found                = 1'b1;
        grant[SRC_W'(cur)]   = 1'b1;
        idx                  = SRC_W'(cur);
      end
      cur = next_idx(cur, NUM_IN);
    end
  end

endmodule

// File: rtl/fanin_merge.sv
// Merges NUM_IN ready/valid producers into one consumer stream through a
// round-robin arbiter and a registered 2-entry buffer (no out_ready->in_ready path).
module fanin_merge
  import fanin_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        cfg_en,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready
);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } buf_entry_t;

  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] grant;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  rr_ptr;
  logic [1:0]        count;
  logic              space;
  logic              push;
  logic              pop;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] push_data;
  buf_entry_t        fifo_q [2];

  assign elig  = in_valid & cfg_en;
  // Space comes from the registered count only, keeping out_ready off the in_ready path.
  assign space = (count < 2'd2);

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SRC_W  (SRC_W)
  ) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .en    (space & ~rst),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign in_ready = grant;
  assign push     = |(in_valid & in_ready);
  assign pop      = out_valid & out_ready;

  // AND-OR select: non-granted ports are masked, so X on them cannot leak through.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      push_data |= in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rr_ptr <= '0;
      // NOTE: the two storage entries are reset because they drive out_data/out_src
      // directly; a deeper RAM-style buffer would leave its storage unreset.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{src: grant_idx, data: push_data};
        wr_ptr         <= ~wr_ptr;
        rr_ptr         <= SRC_W'(next_idx(int'(grant_idx), NUM_IN));
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_q[rd_ptr].data;
  assign out_src   = fifo_q[rd_ptr].src;

  // The grant is gated by space, so a push into a full buffer cannot happen.
  no_push_when_full: assert property (@(posedge clk) disable iff (rst) push |-> (count != 2'd2));

endmodule

// File: doc/fanin_merge.md
Name: fanin_merge

Overview:
- Merges up to NUM_IN independent ready/valid producer streams into a single consumer stream.
- It is the fan-in counterpart of the fanout ready-aggregation logic. The fanout side ANDs enabled destination readies; this block arbitrates enabled source valids.
- Sits between several primitive outputs and one downstream primitive input in the sparse-stream fabric.
- Uses round-robin arbitration into a registered 2-entry output buffer, so there is no combinational path from out_ready to in_ready.

Parameters:
- NUM_IN, 6, number of producer ports.
- DATA_W, 17, stream word width (16-bit payload plus 1 control/token bit).
- SRC_W, $clog2(NUM_IN), width of the source-index tag.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cfg_en  input  NUM_IN  per-input enable. Static configuration; may change between transfers.
- in_valid  input  NUM_IN  producer valid, one bit per port.
- in_data  input  NUM_IN*DATA_W  producer words. Port i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_IN  one-hot or zero grant to producers.
- out_valid  output  1  buffer head valid.
- out_data  output  DATA_W  buffer head word.
- out_src  output  SRC_W  index of the port that supplied the head word.
- out_ready  input  1  consumer ready.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0; out_data=0; out_src=0.
  - Buffer count=0; rr_ptr=0.
  - in_ready=0 while rst is high.
- Eligibility: elig[i] = in_valid[i] & cfg_en[i]. Ports with cfg_en[i]=0 never see in_ready[i]=1.
- Space:
  - space = (count < 2), derived from registered count only.
  - out_ready must not combinationally affect in_ready.
- Arbitration:
  - When space=1 and elig != 0, grant the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_IN.
  - in_ready = one-hot(grant) & {NUM_IN{space}}.
  - When elig==0 or space==0, in_ready=0.
- Push: a transfer occurs when in_valid[g] & in_ready[g]. The buffer writes {g, in_data[g]} at the tail.
- rr_ptr update:
  - On push, rr_ptr <= (g+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
  - Otherwise rr_ptr is unchanged.
- Pop: occurs when out_valid & out_ready. The head advances.
- Buffer:
  - 2-entry FIFO; out_valid = (count != 0).
  - Simultaneous push and pop at count=1 keeps count=1, giving 1 word/cycle sustained throughput.
  - Push at count=2 is impossible by construction.
- Latency: a word pushed at edge t is on out_data/out_src after edge t when the buffer was empty (1-cycle latency).
- Ordering:
  - Words leave in acceptance order.
  - A single port's stream is never reordered or duplicated.
  - Back-to-back words from one port are interleaved with other eligible ports in round-robin order.
- Backpressure: out_ready=0 with count=2 holds out_data/out_src stable, and in_ready=0 until a pop frees space. A pop frees space for the following cycle.
- Config change: clearing cfg_en[i] takes effect the same cycle (combinational). Words already buffered from port i still drain.
- Reset mid-operation:
  - Buffered words are discarded.
  - rr_ptr=0.
  - No in_ready asserted during the reset cycle.
- Invalid data: in_data of non-granted ports is ignored. X on those ports must not propagate.

Decomposition:
- Package fanin_pkg:
  - NUM_IN_DEFAULT=6, DATA_W_DEFAULT=17.
  - Typedef entry_t = struct {src index, data}.
  - Function next_idx(idx, n) for the modulo wrap.
- One sub-module, rr_arbiter: inputs req[NUM_IN], ptr, en; outputs one-hot grant and encoded index.
- Buffer and rr_ptr register live in fanin_merge.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=6'b111111 and cfg_en=6'b111111 -> in_ready=0, out_valid=0. On the first cycle after rst falls, in_ready=6'b000001.
- Round-robin fairness: cfg_en=6'b111111, all valid, out_ready=1, port i drives 0x100+i -> out_src sequence 0,1,2,3,4,5,0,... at 1 word/cycle, with out_data matching.
- Masking: cfg_en=6'b101000, all valid -> only ports 3 and 5 are granted, alternating 3,5,3. in_ready[0..2,4] stay 0.
- Backpressure: out_ready=0, single port 2 valid with words 0x011, 0x012, 0x013 -> two words accepted, then in_ready=0 and out_data=0x011 held. Raising out_ready drains 0x011, 0x012, 0x013 in order.
- Wrap: rr_ptr reaches 0 after port 5 is granted; ports 5 and 0 valid -> grants alternate 0,5,0,5.
- Reset mid-stream: assert rst with count=2 -> out_valid=0 the next cycle. The first grant after release goes to the lowest eligible index.
